// File: rtl/approx_mul_pkg.sv
// Shared mode encoding and sizing helpers for the approximate half-adder multiplier.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_OR    = 2'd1,
        MODE_ELIM  = 2'd2,
        MODE_CARRY = 2'd3
    } mode_t;

    // One 2-bit mode per half-adder column j = 1..W-1 of a row pair.
    function automatic int modeVecWidth(input int w);
        return 2 * (w - 1);
    endfunction

endpackage

// File: rtl/approx_ha_row_pair.sv
// Combinational half-adder array for one pair of partial-product rows,
// with a per-column approximation mode.
module approx_ha_row_pair
    import approx_mul_pkg::*;
#(
    parameter int W = 8,
    localparam int MW = modeVecWidth(W)
) (
    input  logic          xLo_i,
    input  logic          xHi_i,
    input  logic [W-1:0]  y_i,
    input  logic [MW-1:0] mode_i,
    output logic [W:0]    t_o,
    output logic [W-2:0]  bb_o
);

    logic [W-1:1] sum;
    logic [W-1:1] carry;
    logic         aBit;
    logic         bBit;

    // Column j pairs a_j of the lower row with b_{j-1} of the upper row.
    always_comb begin
        sum   = '0;
        carry = '0;
        aBit  = 1'b0;
        bBit  = 1'b0;
        for (int j = 1; j < W; j++) begin
            aBit = y_i[j] & xLo_i;
            bBit = y_i[j-1] & xHi_i;
            case (mode_t'(mode_i[2*(j-1) +: 2]))
                MODE_EXACT: begin
                    sum[j]   = aBit ^ bBit;
                    carry[j] = aBit & bBit;
                end
                MODE_OR:    sum[j]   = aBit | bBit;
                MODE_ELIM:  ;
                MODE_CARRY: carry[j] = aBit;
                default:    ;
            endcase
        end
    end

    assign t_o  = {carry[W-1], sum, y_i[0] & xLo_i};
    assign bb_o = {y_i[W-1] & xHi_i, carry[W-2:1]};

endmodule

// File: rtl/approx_ha_mul_pipe.sv
// Two-stage valid/ready approximate multiplier: row-pair half-adder arrays,
// then a registered reduction to the full product. Mode table is run-time writable.
module approx_ha_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 4,
    parameter logic [2*(W-1)*(W/2)-1:0] MODE_INIT = '0,
    localparam int NP = W / 2,
    localparam int MW = modeVecWidth(W),
    localparam int AW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [MW-1:0]    cfg_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      op_count
);

    localparam int PW = 2 * W;

    logic [MW-1:0]    modeTable_q [NP];
    logic [W:0]       rowT        [NP];
    logic [W-2:0]     rowBb       [NP];

    logic             s1Valid_q;
    logic [W:0]       s1T_q       [NP];
    logic [W-2:0]     s1Bb_q      [NP];
    logic [TAG_W-1:0] s1Tag_q;

    logic             s2Valid_q;
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_d;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      opCount_q;

    logic             s1Load;
    logic             s2Load;

    assign s2Load   = s1Valid_q & (~s2Valid_q | out_ready);
    assign in_ready = ~s1Valid_q | s2Load;
    assign s1Load   = in_valid & in_ready;

    for (genvar p = 0; p < NP; p++) begin : gRowPair
        approx_ha_row_pair #(.W(W)) uRowPair (
            .xLo_i  (in_x[2*p]),
            .xHi_i  (in_x[2*p+1]),
            .y_i    (in_y),
            .mode_i (modeTable_q[p]),
            .t_o    (rowT[p]),
            .bb_o   (rowBb[p])
        );
    end

    // Operands accepted on the same edge as a write still see the old modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) modeTable_q[p] <= MODE_INIT[p*MW +: MW];
        end else if (cfg_we && (int'(cfg_addr) < NP)) begin
            modeTable_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Tag_q   <= '0;
            for (int p = 0; p < NP; p++) begin
                s1T_q[p]  <= '0;
                s1Bb_q[p] <= '0;
            end
        end else if (s1Load) begin
            s1Valid_q <= 1'b1;
            s1Tag_q   <= in_tag;
            for (int p = 0; p < NP; p++) begin
                s1T_q[p]  <= rowT[p];
                s1Bb_q[p] <= rowBb[p];
            end
        end else if (s2Load) begin
            s1Valid_q <= 1'b0;
        end
    end

    // Each pair contributes G_p = t + (bb << 2), weighted by 4^p.
    always_comb begin
        prod_d = '0;
        for (int p = 0; p < NP; p++) begin
            prod_d = prod_d + ((PW'(s1T_q[p]) + (PW'(s1Bb_q[p]) << 2)) << (2 * p));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            prod_q    <= '0;
            tag_q     <= '0;
        end else if (s2Load) begin
            s2Valid_q <= 1'b1;
            prod_q    <= prod_d;
            tag_q     <= s1Tag_q;
        end else if (out_ready) begin
            s2Valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opCount_q <= '0;
        end else if (s2Valid_q && out_ready && (opCount_q != '1)) begin
            opCount_q <= opCount_q + 32'd1;
        end
    end

    assign out_valid = s2Valid_q;
    assign out_prod  = prod_q;
    assign out_tag   = tag_q;
    assign op_count  = opCount_q;

endmodule

// File: tb/tb_approx_ha_mul_pipe.sv
// Directed bench for approx_ha_mul_pipe (W=8) with a column-weight reference model
// and a scoreboard checked every cycle.
module tb_approx_ha_mul_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [3:0]  in_tag;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [13:0] cfg_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [3:0]  out_tag;
    logic [31:0] op_count;

    int nChecks = 0;
    int nFails  = 0;

    approx_ha_mul_pipe #(.W(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference: each pair adds its column contributions at their binary weights.
    function automatic logic [15:0] modelProd(input int x, input int y, input logic [13:0] m [4]);
        longint total = 0;
        for (int p = 0; p < 4; p++) begin
            int xl = (x >> (2 * p)) & 1;
            int xh = (x >> (2 * p + 1)) & 1;
            longint g = (y & 1) & xl;
            for (int j = 1; j < 8; j++) begin
                int a  = ((y >> j) & 1) & xl;
                int b  = ((y >> (j - 1)) & 1) & xh;
                int md = int'((m[p] >> (2 * (j - 1))) & 14'd3);
                case (md)
                    0: g += longint'(a + b) << j;
                    1: g += longint'(a | b) << j;
                    3: g += longint'(a) << (j + 1);
                    default: ;
                endcase
            end
            g += longint'(((y >> 7) & 1) & xh) << 8;
            total += g << (2 * p);
        end
        return 16'(total);
    endfunction

    logic [15:0] expProdQ [$];
    logic [3:0]  expTagQ  [$];
    logic [13:0] tbModes  [4];
    longint      modelCount;
    logic        prevHold;
    logic [15:0] prevProd;
    logic [3:0]  prevTag;

    // Scoreboard: predicts each accepted operation and checks outputs every cycle.
    always @(negedge clk) begin
        if (rst) begin
            expProdQ.delete();
            expTagQ.delete();
            for (int p = 0; p < 4; p++) tbModes[p] = '0;
            modelCount = 0;
            prevHold   = 1'b0;
        end else begin
            checkOutput("op_count", 64'(op_count), 64'(modelCount));
            if (prevHold) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_prod", 64'(out_prod), 64'(prevProd));
                checkOutput("hold_tag", 64'(out_tag), 64'(prevTag));
            end
            if (out_valid && out_ready) begin
                if (expProdQ.size() == 0) begin
                    reportFail("unexpected_output");
                end else begin
                    checkOutput("sb_prod", 64'(out_prod), 64'(expProdQ.pop_front()));
                    checkOutput("sb_tag", 64'(out_tag), 64'(expTagQ.pop_front()));
                end
                if (modelCount != 64'hFFFF_FFFF) modelCount++;
            end
            if (in_valid && in_ready) begin
                expProdQ.push_back(modelProd(int'(in_x), int'(in_y), tbModes));
                expTagQ.push_back(in_tag);
            end
            if (cfg_we && int'(cfg_addr) < 4) tbModes[cfg_addr] = cfg_data;
            prevHold = out_valid && !out_ready;
            prevProd = out_prod;
            prevTag  = out_tag;
        end
    end

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 input logic [3:0] tag, output int stalls);
        stalls   = 0;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
        in_valid = 1'b1;
        #2;
        while (!in_ready && stalls < 100) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        if (!in_ready) reportFail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output logic [15:0] p, output logic [3:0] tg);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) reportFail("result_timeout");
        p  = out_prod;
        tg = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic runOne(input logic [7:0] x, input logic [7:0] y, input logic [3:0] tag,
                          output logic [15:0] p);
        int          st;
        logic [3:0]  tg;
        applyStimulus(x, y, tag, st);
        waitResult(p, tg);
    endtask

    task automatic writeMode(input logic [1:0] addr, input logic [13:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [13:0] mEx [4];
        logic [13:0] mTest [4];
        logic [15:0] p;
        int          st;
        logic [31:0] countBefore;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_tag    = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        out_ready = 1'b1;

        // Pin the reference model against hand-computed values.
        for (int i = 0; i < 4; i++) begin
            mEx[i]   = '0;
            mTest[i] = '0;
        end
        checkOutput("model_exact", 64'(modelProd(255, 255, mEx)), 64'd65025);
        mTest[0] = 14'h1555;
        checkOutput("model_or", 64'(modelProd(3, 3, mTest)), 64'd7);
        mTest[0] = 14'h2AAA;
        checkOutput("model_elim", 64'(modelProd(3, 3, mTest)), 64'd1);
        mTest[0] = 14'h3FFF;
        checkOutput("model_carry", 64'(modelProd(3, 3, mTest)), 64'd5);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_prod", 64'(out_prod), 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_op_count", 64'(op_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] exact 255x255 and latency");
        applyStimulus(8'd255, 8'd255, 4'd1, st);
        checkOutput("lat_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_prod", 64'(out_prod), 64'd65025);
        checkOutput("lat_tag", 64'(out_tag), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("lat_count", 64'(op_count), 64'd1);
        checkOutput("lat_drained", 64'(out_valid), 64'd0);

        $display("[TB] pair 0 approximation modes");
        writeMode(2'd0, 14'h1555);
        runOne(8'd3, 8'd3, 4'd2, p);
        checkOutput("mode_or", 64'(p), 64'd7);
        writeMode(2'd0, 14'h2AAA);
        runOne(8'd3, 8'd3, 4'd3, p);
        checkOutput("mode_elim", 64'(p), 64'd1);
        writeMode(2'd0, 14'h3FFF);
        runOne(8'd3, 8'd3, 4'd4, p);
        checkOutput("mode_carry", 64'(p), 64'd5);
        writeMode(2'd0, 14'h0000);

        $display("[TB] back-to-back exact stream");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i), st);
            checkOutput("stream_no_stall", 64'(st), 64'd0);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("stream_drain", 64'(expProdQ.size()), 64'd0);

        $display("[TB] stream with random mode table");
        for (int i = 0; i < 4; i++) writeMode(2'(i), 14'($urandom_range(0, 16383)));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i + 3), st);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rand_drain", 64'(expProdQ.size()), 64'd0);
        for (int i = 0; i < 4; i++) writeMode(2'(i), 14'h0000);

        $display("[TB] backpressure");
        countBefore = op_count;
        out_ready   = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    applyStimulus(8'(17 * i + 9), 8'(29 * i + 3), 4'(i + 8), st);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
                checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bp_drain", 64'(expProdQ.size()), 64'd0);
        checkOutput("bp_count", 64'(op_count - countBefore), 64'd5);

        $display("[TB] mode write in the accepting cycle");
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 14'h2AAA;
        applyStimulus(8'd3, 8'd3, 4'd5, st);
        cfg_we = 1'b0;
        begin
            logic [3:0] tg;
            waitResult(p, tg);
        end
        checkOutput("same_cycle_old", 64'(p), 64'd9);
        runOne(8'd3, 8'd3, 4'd6, p);
        checkOutput("same_cycle_new", 64'(p), 64'd1);

        $display("[TB] reset with operations in flight");
        writeMode(2'd0, 14'h1555);
        applyStimulus(8'd100, 8'd200, 4'd7, st);
        applyStimulus(8'd50, 8'd60, 4'd8, st);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_op_count", 64'(op_count), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runOne(8'd3, 8'd3, 4'd9, p);
        checkOutput("post_rst_prod", 64'(p), 64'd9);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_drain", 64'(expProdQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
